// File: rtl/msrv32_alu_issue_stage.sv
// Issue stage feeding the msrv32 ALU: 2-entry skid queue with shift masking.
// Define MSRV32_ISSUE_FWD_EN to build writeback forwarding into captured/held entries.
module msrv32_alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            flush_in,
  input  logic            in_valid_in,
  output logic            in_ready_out,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_imm_in,
  input  logic            use_imm_in,
  input  logic [RA_W-1:0] rs1_addr_in,
  input  logic [RA_W-1:0] rs2_addr_in,
  input  logic [RA_W-1:0] rd_addr_in,
  input  logic [3:0]      opcode_in,
  input  logic            wb_valid_in,
  input  logic [RA_W-1:0] wb_rd_addr_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic            out_valid_out,
  input  logic            out_ready_in,
  output logic [XLEN-1:0] op_1_out,
  output logic [XLEN-1:0] op_2_out,
  output logic [3:0]      opcode_out,
  output logic [RA_W-1:0] rd_addr_out
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] op_1;
    logic [XLEN-1:0] op_2;
    logic [3:0]      opcode;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            use_imm;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d;
  entry_t raw, cap, head_fwd, tail_fwd;
  logic   push, pop;

  // Shifts only ever use the low 5 bits of op_2, so the rest is cleared on entry.
  function automatic logic [XLEN-1:0] mask_op2(input logic [3:0] opc, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    if (opc == 4'b0001 || opc == 4'b0101 || opc == 4'b1101)
      r = {{(XLEN-5){1'b0}}, v[4:0]};
    return r;
  endfunction

  always_comb begin
    raw         = '0;
    raw.op_1    = rs1_data_in;
    raw.op_2    = mask_op2(opcode_in, rs2_imm_in);
    raw.opcode  = opcode_in;
    raw.rd      = rd_addr_in;
    raw.rs1     = rs1_addr_in;
    raw.rs2     = rs2_addr_in;
    raw.use_imm = use_imm_in;
  end

`ifdef MSRV32_ISSUE_FWD_EN
  logic wb_live;
  assign wb_live = wb_valid_in && (wb_rd_addr_in != '0);

  function automatic entry_t fwd(input entry_t e, input logic live,
                                 input logic [RA_W-1:0] wrd, input logic [XLEN-1:0] wd);
    entry_t r;
    r = e;
    if (live && e.rs1 == wrd)
      r.op_1 = wd;
    if (live && !e.use_imm && e.rs2 == wrd)
      r.op_2 = mask_op2(e.opcode, wd);
    return r;
  endfunction

  assign cap      = fwd(raw, wb_live, wb_rd_addr_in, wb_data_in);
  assign head_fwd = fwd(head_q, wb_live, wb_rd_addr_in, wb_data_in);
  assign tail_fwd = fwd(tail_q, wb_live, wb_rd_addr_in, wb_data_in);
`else
  logic unused_fwd;
  assign unused_fwd = ^{wb_valid_in, wb_rd_addr_in, wb_data_in};
  assign cap        = raw;
  assign head_fwd   = head_q;
  assign tail_fwd   = tail_q;
`endif

  assign in_ready_out  = (state_q != FULL);
  assign out_valid_out = (state_q != EMPTY);
  assign push          = in_valid_in && in_ready_out && !flush_in;
  assign pop           = out_valid_out && out_ready_in;

  assign op_1_out    = head_q.op_1;
  assign op_2_out    = head_q.op_2;
  assign opcode_out  = head_q.opcode;
  assign rd_addr_out = head_q.rd;

  // A popped entry is simply overwritten, which discards any same-cycle forward into it.
  always_comb begin
    state_d = state_q;
    head_d  = head_fwd;
    tail_d  = tail_fwd;
    if (flush_in) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          head_d = head_q;
          if (push) begin
            head_d  = cap;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_d  = cap;
              state_d = FULL;
            end
            2'b01:   state_d = EMPTY;
            2'b11:   head_d  = cap;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_fwd;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_msrv32_alu_issue_stage.sv
// Scoreboard bench for msrv32_alu_issue_stage; expectations follow MSRV32_ISSUE_FWD_EN.
module tb_msrv32_alu_issue_stage;

`ifdef MSRV32_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_imm_in;
  logic        use_imm_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;
  logic [4:0]  rd_addr_in;
  logic [3:0]  opcode_in;
  logic        wb_valid_in;
  logic [4:0]  wb_rd_addr_in;
  logic [31:0] wb_data_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] op_1_out;
  logic [31:0] op_2_out;
  logic [3:0]  opcode_out;
  logic [4:0]  rd_addr_out;

  typedef struct {
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic [3:0]  opcode;
    logic [4:0]  rd;
  } exp_t;

  exp_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pop_idx    = 0;

  msrv32_alu_issue_stage #(.XLEN(32), .RA_W(5)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .flush_in(flush_in),
    .in_valid_in(in_valid_in),
    .in_ready_out(in_ready_out),
    .rs1_data_in(rs1_data_in),
    .rs2_imm_in(rs2_imm_in),
    .use_imm_in(use_imm_in),
    .rs1_addr_in(rs1_addr_in),
    .rs2_addr_in(rs2_addr_in),
    .rd_addr_in(rd_addr_in),
    .opcode_in(opcode_in),
    .wb_valid_in(wb_valid_in),
    .wb_rd_addr_in(wb_rd_addr_in),
    .wb_data_in(wb_data_in),
    .out_valid_out(out_valid_out),
    .out_ready_in(out_ready_in),
    .op_1_out(op_1_out),
    .op_2_out(op_2_out),
    .opcode_out(opcode_out),
    .rd_addr_out(rd_addr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] r1d, input logic [31:0] r2,
                               input logic imm, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] rd, input logic [3:0] opc);
    in_valid_in = v;
    rs1_data_in = r1d;
    rs2_imm_in  = r2;
    use_imm_in  = imm;
    rs1_addr_in = a1;
    rs2_addr_in = a2;
    rd_addr_in  = rd;
    opcode_in   = opc;
  endtask

  task automatic expectOut(input logic [31:0] o1, input logic [31:0] o2,
                           input logic [3:0] opc, input logic [4:0] rd);
    exp_t e;
    e.op_1 = o1;
    e.op_2 = o2;
    e.opcode = opc;
    e.rd = rd;
    expq.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 4'h0);
  endtask

  task automatic setWb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid_in   = v;
    wb_rd_addr_in = a;
    wb_data_in    = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output transfer is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid_out && out_ready_in) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_output", {31'b0, out_valid_out}, 32'h0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput($sformatf("pop%0d_op_1", pop_idx), op_1_out, e.op_1);
        checkOutput($sformatf("pop%0d_op_2", pop_idx), op_2_out, e.op_2);
        checkOutput($sformatf("pop%0d_opcode", pop_idx), {28'b0, opcode_out}, {28'b0, e.opcode});
        checkOutput($sformatf("pop%0d_rd", pop_idx), {27'b0, rd_addr_out}, {27'b0, e.rd});
        pop_idx++;
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    flush_in     = 1'b0;
    out_ready_in = 1'b0;
    idle();
    setWb(1'b0, 5'd0, 32'h0);
    #3;
    checkOutput("reset_out_valid", {31'b0, out_valid_out}, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready_out}, 32'h1);
    checkOutput("reset_op_1", op_1_out, 32'h0);
    checkOutput("reset_op_2", op_2_out, 32'h0);
    checkOutput("reset_opcode", {28'b0, opcode_out}, 32'h0);
    checkOutput("reset_rd", {27'b0, rd_addr_out}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Single bundle, one-cycle latency.
    out_ready_in = 1'b1;
    applyStimulus(1'b1, 32'd5, 32'd3, 1'b1, 5'd1, 5'd2, 5'd7, 4'b0000);
    expectOut(32'd5, 32'd3, 4'b0000, 5'd7);
    step();
    idle();
    checkOutput("single_valid", {31'b0, out_valid_out}, 32'h1);
    step();
    checkOutput("single_drained", {31'b0, out_valid_out}, 32'h0);

    // Fill to FULL with the consumer stalled; third bundle must be refused.
    out_ready_in = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'h20, 1'b1, 5'd0, 5'd0, 5'd1, 4'b0110);
    expectOut(32'h10, 32'h20, 4'b0110, 5'd1);
    step();
    checkOutput("fill1_in_ready", {31'b0, in_ready_out}, 32'h1);
    applyStimulus(1'b1, 32'h30, 32'h40, 1'b1, 5'd0, 5'd0, 5'd2, 4'b0100);
    expectOut(32'h30, 32'h40, 4'b0100, 5'd2);
    step();
    checkOutput("fill2_in_ready", {31'b0, in_ready_out}, 32'h0);
    applyStimulus(1'b1, 32'h50, 32'h60, 1'b1, 5'd0, 5'd0, 5'd3, 4'b0111);
    step();
    checkOutput("fill3_in_ready", {31'b0, in_ready_out}, 32'h0);
    checkOutput("fill3_head_stable", op_1_out, 32'h10);
    idle();
    out_ready_in = 1'b1;
    step();
    checkOutput("drain_in_ready", {31'b0, in_ready_out}, 32'h1);
    checkOutput("drain_head_moved", op_1_out, 32'h30);
    step();
    checkOutput("drain_empty", {31'b0, out_valid_out}, 32'h0);

    // Back-to-back throughput and shift masking.
    applyStimulus(1'b1, 32'd100, 32'd1, 1'b1, 5'd0, 5'd0, 5'd10, 4'b1000);
    expectOut(32'd100, 32'd1, 4'b1000, 5'd10);
    step();
    checkOutput("tput1_in_ready", {31'b0, in_ready_out}, 32'h1);
    applyStimulus(1'b1, 32'h1, 32'hFFFF_FF23, 1'b1, 5'd0, 5'd0, 5'd11, 4'b0001);
    expectOut(32'h1, 32'h0000_0003, 4'b0001, 5'd11);
    step();
    checkOutput("tput2_in_ready", {31'b0, in_ready_out}, 32'h1);
    applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0045, 1'b0, 5'd0, 5'd0, 5'd12, 4'b1101);
    expectOut(32'h8000_0000, 32'h0000_0005, 4'b1101, 5'd12);
    step();
    applyStimulus(1'b1, 32'h7, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd13, 4'b0011);
    expectOut(32'h7, 32'hFFFF_FFFF, 4'b0011, 5'd13);
    step();
    idle();
    step();
    step();

    // Capture-time forwarding; immediates are never replaced.
    setWb(1'b1, 5'd6, 32'hFFFF_FFE7);
    applyStimulus(1'b1, 32'h80, 32'h1, 1'b0, 5'd6, 5'd6, 5'd14, 4'b0101);
    expectOut(FWD ? 32'hFFFF_FFE7 : 32'h80, FWD ? 32'h7 : 32'h1, 4'b0101, 5'd14);
    step();
    applyStimulus(1'b1, 32'h1, 32'h99, 1'b1, 5'd6, 5'd6, 5'd15, 4'b0000);
    expectOut(FWD ? 32'hFFFF_FFE7 : 32'h1, 32'h99, 4'b0000, 5'd15);
    step();
    idle();
    setWb(1'b0, 5'd0, 32'h0);
    step();
    step();

    // Forwarding into a held head, and x0 never forwards.
    out_ready_in = 1'b0;
    applyStimulus(1'b1, 32'h11, 32'h22, 1'b0, 5'd4, 5'd0, 5'd3, 4'b0111);
    step();
    idle();
    setWb(1'b1, 5'd4, 32'hDEAD_BEEF);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("held_fwd_op_1", op_1_out, FWD ? 32'hDEAD_BEEF : 32'h11);
    setWb(1'b1, 5'd0, 32'hCAFE_F00D);
    step();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("held_x0_op_2", op_2_out, 32'h22);
    checkOutput("held_x0_op_1", op_1_out, FWD ? 32'hDEAD_BEEF : 32'h11);
    expectOut(FWD ? 32'hDEAD_BEEF : 32'h11, 32'h22, 4'b0111, 5'd3);
    out_ready_in = 1'b1;
    step();
    step();

    // Flush in FULL together with a push: nothing survives.
    out_ready_in = 1'b0;
    applyStimulus(1'b1, 32'hA1, 32'hB1, 1'b1, 5'd0, 5'd0, 5'd20, 4'b0000);
    step();
    applyStimulus(1'b1, 32'hA2, 32'hB2, 1'b1, 5'd0, 5'd0, 5'd21, 4'b0000);
    step();
    applyStimulus(1'b1, 32'hA3, 32'hB3, 1'b1, 5'd0, 5'd0, 5'd22, 4'b0000);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    idle();
    checkOutput("flush_out_valid", {31'b0, out_valid_out}, 32'h0);
    checkOutput("flush_in_ready", {31'b0, in_ready_out}, 32'h1);
    out_ready_in = 1'b1;
    step();
    step();
    step();

    // Asynchronous reset mid-cycle with a bundle held.
    out_ready_in = 1'b0;
    applyStimulus(1'b1, 32'h55, 32'h66, 1'b1, 5'd0, 5'd0, 5'd9, 4'b0100);
    step();
    idle();
    checkOutput("areset_pre_valid", {31'b0, out_valid_out}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", {31'b0, out_valid_out}, 32'h0);
    checkOutput("areset_in_ready", {31'b0, in_ready_out}, 32'h1);
    checkOutput("areset_op_1", op_1_out, 32'h0);
    checkOutput("areset_rd", {27'b0, rd_addr_out}, 32'h0);
    step();
    rst_n = 1'b1;
    out_ready_in = 1'b1;
    step();
    step();

    checkOutput("scoreboard_empty", expq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/msrv32_alu_issue_stage.md
# msrv32_alu_issue_stage

Pipeline issue stage directly upstream of the msrv32 ALU. It accepts decoded operand/opcode bundles from the decode stage over a valid/ready handshake and buffers them in a 2-entry skid queue. It forwards the writeback result into operands that are captured or held, masks shift amounts, and presents registered `op_1`/`op_2`/`opcode` to the ALU. Branch and trap logic can flush it.

## Interface
- `XLEN`, 32: operand width; the ALU consumes 32 bits, so only 32 is supported.
- `RA_W`, 5: register address width.
- `ms_riscv32_mp_clk_in`  in  1  clock; all state updates on the rising edge.
- `ms_riscv32_mp_rst_in`  in  1  reset, asynchronous, active-low.
- `flush_in`  in  1  synchronous flush; empties the queue.
- `in_valid_in`  in  1  decode bundle valid.
- `in_ready_out`  out  1  stage can accept a bundle this cycle.
- `rs1_data_in`  in  XLEN  rs1 register-file value.
- `rs2_imm_in`  in  XLEN  rs2 value, or the immediate when `use_imm_in`=1.
- `use_imm_in`  in  1  `rs2_imm_in` is an immediate; never forwarded.
- `rs1_addr_in`, `rs2_addr_in`, `rd_addr_in`  in  RA_W each  register addresses.
- `opcode_in`  in  4  ALU opcode: 0000 add, 1000 sub, 0010 slt, 0011 sltu, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra.
- `wb_valid_in`  in  1  writeback is writing `wb_data_in` to `wb_rd_addr_in`.
- `wb_rd_addr_in`  in  RA_W  writeback destination.
- `wb_data_in`  in  XLEN  writeback value.
- `out_valid_out`  out  1  head bundle valid toward the ALU.
- `out_ready_in`  in  1  downstream accepts the head bundle.
- `op_1_out`, `op_2_out`  out  XLEN  ALU operands.
- `opcode_out`  out  4  ALU opcode.
- `rd_addr_out`  out  RA_W  destination carried alongside the bundle.

## Operation
- Storage: 2 entries, head and tail. Each entry holds op_1, op_2, opcode, rd, rs1, rs2 and use_imm.
- State machine on the occupancy count:
  - EMPTY (0): push → ONE.
  - ONE (1): push only → FULL; pop only → EMPTY; push and pop together → ONE, with the new bundle becoming head.
  - FULL (2): pop → ONE, with the tail moving to head; a push is impossible because `in_ready_out`=0.
- `in_ready_out` = (state != FULL), decoded from the state register (no combinational path from `out_ready_in`).
- Push = `in_valid_in` & `in_ready_out` & !`flush_in`. Pop = `out_valid_out` & `out_ready_in`.
- `out_valid_out` = (state != EMPTY). The outputs always show the head entry fields.
- Shift masking at capture: for opcodes 0001, 0101 and 1101, stored op_2[31:5] is zeroed, so the ALU shifts by 0..31 only.
- Forwarding (see Configuration): a match requires `wb_valid_in`=1, `wb_rd_addr_in`!=0 and an equal address.
  - At capture, a matching rs1 replaces op_1 with `wb_data_in`.
  - At capture, a matching rs2 with use_imm=0 replaces op_2 with `wb_data_in`, masked as above for shift opcodes.
  - Every held entry (head and tail) applies the same comparison each cycle and overwrites its operands on a match.
  - A pop and an overwrite in the same cycle: the popped entry's update is discarded.
- Flush: the next state is EMPTY and all entries are invalidated. Flush has priority over a simultaneous push and pop; the input bundle is dropped.
- x0: register address 0 never forwards.

## Timing
- Latency: a bundle pushed in cycle N is visible on the outputs in cycle N+1 (if the queue was EMPTY).
- Throughput: 1 bundle/cycle while `out_ready_in`=1.
- From FULL, a pop in cycle N raises `in_ready_out` in N+1.
- `out_valid_out` and the data outputs hold stable while `out_valid_out`=1 and `out_ready_in`=0, except when a forwarding update changes an operand.
- Reset (async, active-low): state EMPTY, so `in_ready_out`=1 and `out_valid_out`=0. `op_1_out`, `op_2_out`, `opcode_out` and `rd_addr_out` are all 0. Asserting reset mid-transfer drops all bundles immediately.
- `flush_in` takes effect at the next edge: `out_valid_out`=0 in the following cycle.

## Configuration
- `MSRV32_ISSUE_FWD_EN` defined: writeback forwarding into captured and held entries is active as described.
- Not defined: the forwarding comparators are not built. The `wb_*` inputs are ignored, and operands are stored exactly as received (shift masking still applies).

## Test plan
- Reset, then push {rs1_data=5, rs2_imm=3, opcode=0000, rd=7} with `out_ready_in`=1 → next cycle `out_valid_out`=1, op_1=5, op_2=3, rd=7; following cycle `out_valid_out`=0.
- Hold `out_ready_in`=0 and push 3 bundles → `in_ready_out`=0 after the 2nd; the 3rd is not accepted. Raise ready → bundles 1 and 2 drain in order; `in_ready_out`=1 one cycle after the first pop.
- Push opcode 0001 with rs2_imm=0xFFFF_FF23 → `op_2_out`=0x0000_0003.
- With FWD_EN, held head rs1=4, `wb_valid_in`=1, wb_rd=4, wb_data=0xDEAD_BEEF → `op_1_out`=0xDEAD_BEEF next cycle. The same case with wb_rd=0 → no change. Without FWD_EN → no change.
- In FULL state, assert `flush_in` together with `in_valid_in`=1 → next cycle `out_valid_out`=0, `in_ready_out`=1, and no bundle is ever emitted.
- Push a bundle, then drop `ms_riscv32_mp_rst_in` asynchronously mid-cycle → the outputs go to 0 / EMPTY immediately, without waiting for a clock edge.
